// File: rtl/layered_cnu_sched_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// layered_cnu_sched_ctrl_pkg
// Shared definitions for the layered-decoder CNU scheduling controller:
//   - FSM state encoding (state_t) and its width ST_W
//   - default latency/geometry constants used by the controller, the datapath
//     and the testbench
//   - small helper functions for index and counter widths
// -----------------------------------------------------------------------------
package layered_cnu_sched_ctrl_pkg;

    localparam int FSM_STATE_NUM = 11;
    localparam int ST_W          = $clog2(FSM_STATE_NUM);

    typedef enum logic [ST_W-1:0] {
        ST_RESET_WAIT = ST_W'(0),
        ST_FRAME_IDLE = ST_W'(1),
        ST_VNU_PEND   = ST_W'(2),
        ST_MEM_FETCH  = ST_W'(3),
        ST_CNU_PIPE   = ST_W'(4),
        ST_CNU_OUT    = ST_W'(5),
        ST_BS_WB      = ST_W'(6),
        ST_PAGE_ALIGN = ST_W'(7),
        ST_MEM_WB     = ST_W'(8),
        ST_LAYER_WAIT = ST_W'(9),
        ST_DONE       = ST_W'(10)
    } state_t;

    localparam int DEF_LAYER_NUM          = 3;
    localparam int DEF_MAX_ITER           = 10;
    localparam int DEF_MEM_RD_LEVEL       = 2;
    localparam int DEF_CNU_PIPELINE_LEVEL = 4;
    localparam int DEF_PERMUTATION_LEVEL  = 2;
    localparam int DEF_PAGE_ALIGN_LEVEL   = 1;
    localparam int DEF_RESET_CYCLE        = 100;

    // Width of a 0-based index over n items; never narrower than one bit so a
    // single-iteration configuration still has a legal port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/layered_cnu_sched_ctrl_layer_iter_counter.sv
// -----------------------------------------------------------------------------
// layered_cnu_sched_ctrl_layer_iter_counter  (layer_iter_counter)
// Binary layer / iteration index counters for the layered decoder.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clr             clear both indices (has priority over i_adv)
//   i_adv             advance to the next layer; the layer index wraps at
//                     LAYER_NUM-1 and the iteration index increments on wrap
//   o_layer_idx       current layer, 0-based
//   o_iter_idx        current iteration, 0-based
//   o_last_layer      o_layer_idx == LAYER_NUM-1
//   o_last_iter       o_iter_idx  == MAX_ITER-1
// -----------------------------------------------------------------------------
module layered_cnu_sched_ctrl_layer_iter_counter
    import layered_cnu_sched_ctrl_pkg::*;
#(
    parameter  int LAYER_NUM = DEF_LAYER_NUM,
    parameter  int MAX_ITER  = DEF_MAX_ITER,
    localparam int LW        = idx_width(LAYER_NUM),
    localparam int IW        = idx_width(MAX_ITER)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [LW-1:0] o_layer_idx,
    output logic [IW-1:0] o_iter_idx,
    output logic          o_last_layer,
    output logic          o_last_iter
);

    logic [LW-1:0] r_layer;
    logic [IW-1:0] r_iter;
    logic          w_last_layer;
    logic          w_last_iter;

    assign w_last_layer = (r_layer == LW'(LAYER_NUM - 1));
    assign w_last_iter  = (r_iter  == IW'(MAX_ITER - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_layer <= '0;
            r_iter  <= '0;
        end else if (i_clr) begin
            r_layer <= '0;
            r_iter  <= '0;
        end else if (i_adv) begin
            if (w_last_layer) begin
                r_layer <= '0;
                // The controller terminates before advancing past the final
                // iteration; wrapping here just keeps the counter bounded.
                r_iter  <= w_last_iter ? '0 : r_iter + 1'b1;
            end else begin
                r_layer <= r_layer + 1'b1;
            end
        end
    end

    assign o_layer_idx  = r_layer;
    assign o_iter_idx   = r_iter;
    assign o_last_layer = w_last_layer;
    assign o_last_iter  = w_last_iter;

endmodule

// File: rtl/layered_cnu_sched_ctrl.sv
// -----------------------------------------------------------------------------
// layered_cnu_sched_ctrl
// Per-layer scheduler for a layered LDPC decoder: V2C fetch, CNU pipeline,
// barrel-shift write-back, page alignment and C2V memory write, plus layer and
// iteration tracking and frame hand-in/hand-out.
//
// Ports
//   read_clk, rst      clock; asynchronous active-high reset
//   fsm_en             0 = synchronous return to FRAME_IDLE, indices cleared
//   frame_valid        frame loaded, request to decode
//   frame_ready        controller accepts a frame (FRAME_IDLE only)
//   vnu_update_pend    VNU IB-RAMs still updating; holds off MEM_FETCH
//   layer_finish       one-cycle pulse: datapath finished the current layer
//   v2c_mem_fetch      first MEM_FETCH cycle
//   cnu_rd             CNU_PIPE and CNU_OUT
//   c2v_bs_en          first BS_WB cycle
//   c2v_pa_en          throughout PAGE_ALIGN
//   c2v_mem_we         MEM_WB
//   layer_idx/iter_idx current layer / iteration, 0-based
//   last_layer         layer_idx == LAYER_NUM-1
//   frame_done         one-cycle pulse when a frame ends
//   proto_err          sticky: layer_finish seen outside LAYER_WAIT
//   state              current FSM state (debug)
//
// Optional feature macro: CNU_CTRL_EARLY_TERM_EN
//   adds input syndrome_ok and output early_term; a satisfied syndrome at the
//   end of the last layer ends the frame before MAX_ITER iterations.
//
// Frame handshake: a frame transfers on a rising clock edge where both
// frame_valid and frame_ready are 1. frame_ready depends only on the state, so
// frame_valid may be held high without being consumed twice; frame_valid seen
// while frame_ready is 0 has no effect.
// -----------------------------------------------------------------------------
module layered_cnu_sched_ctrl
    import layered_cnu_sched_ctrl_pkg::*;
#(
    parameter  int LAYER_NUM          = DEF_LAYER_NUM,
    parameter  int MAX_ITER           = DEF_MAX_ITER,
    parameter  int MEM_RD_LEVEL       = DEF_MEM_RD_LEVEL,
    parameter  int CNU_PIPELINE_LEVEL = DEF_CNU_PIPELINE_LEVEL,
    parameter  int PERMUTATION_LEVEL  = DEF_PERMUTATION_LEVEL,
    parameter  int PAGE_ALIGN_LEVEL   = DEF_PAGE_ALIGN_LEVEL,
    parameter  int RESET_CYCLE        = DEF_RESET_CYCLE,
    localparam int LW                 = idx_width(LAYER_NUM),
    localparam int IW                 = idx_width(MAX_ITER)
) (
    input  logic            read_clk,
    input  logic            rst,
    input  logic            fsm_en,
    input  logic            frame_valid,
    output logic            frame_ready,
    input  logic            vnu_update_pend,
    input  logic            layer_finish,
    output logic            v2c_mem_fetch,
    output logic            cnu_rd,
    output logic            c2v_bs_en,
    output logic            c2v_pa_en,
    output logic            c2v_mem_we,
    output logic [LW-1:0]   layer_idx,
    output logic [IW-1:0]   iter_idx,
    output logic            last_layer,
    output logic            frame_done,
    output logic            proto_err,
`ifdef CNU_CTRL_EARLY_TERM_EN
    input  logic            syndrome_ok,
    output logic            early_term,
`endif
    output logic [ST_W-1:0] state
);

    // One down-counter serves every multi-cycle stage; it is wide enough for
    // the longest stage.
    localparam int CW = $clog2(max4(MEM_RD_LEVEL, CNU_PIPELINE_LEVEL,
                                    PERMUTATION_LEVEL, PAGE_ALIGN_LEVEL) + 1);
    localparam int RW = $clog2(RESET_CYCLE + 1);

    localparam logic [CW-1:0] MEM_LOAD  = CW'(MEM_RD_LEVEL - 1);
    // CNU_OUT supplies the final CNU cycle, so CNU_PIPE runs one cycle short.
    localparam logic [CW-1:0] CNU_LOAD  = CW'(CNU_PIPELINE_LEVEL - 2);
    localparam logic [CW-1:0] PERM_LOAD = CW'(PERMUTATION_LEVEL - 1);
    localparam logic [CW-1:0] PA_LOAD   = CW'((PAGE_ALIGN_LEVEL > 0) ? PAGE_ALIGN_LEVEL - 1 : 0);
    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLE - 1);

    state_t        r_state;
    logic [CW-1:0] r_stage_cnt;
    logic [RW-1:0] r_rst_cnt;
    logic          r_proto_err;

    logic          w_last_layer;
    logic          w_last_iter;
    logic          w_term;
    logic          w_idx_clr;
    logic          w_idx_adv;
    logic          w_stage_zero;

`ifdef CNU_CTRL_EARLY_TERM_EN
    logic          r_early;
    logic          w_early_hit;

    assign w_early_hit = w_last_layer && syndrome_ok;
    assign w_term      = (w_last_layer && w_last_iter) || w_early_hit;
`else
    assign w_term      = w_last_layer && w_last_iter;
`endif

    assign w_stage_zero = (r_stage_cnt == '0);

    // Index updates land on the same edge as the matching state transition.
    assign w_idx_clr = !fsm_en || ((r_state == ST_FRAME_IDLE) && frame_valid);
    assign w_idx_adv = fsm_en && (r_state == ST_LAYER_WAIT) && layer_finish && !w_term;

    layered_cnu_sched_ctrl_layer_iter_counter #(
        .LAYER_NUM (LAYER_NUM),
        .MAX_ITER  (MAX_ITER)
    ) u_layer_iter_counter (
        .i_clk        (read_clk),
        .i_rst        (rst),
        .i_clr        (w_idx_clr),
        .i_adv        (w_idx_adv),
        .o_layer_idx  (layer_idx),
        .o_iter_idx   (iter_idx),
        .o_last_layer (w_last_layer),
        .o_last_iter  (w_last_iter)
    );

    always_ff @(posedge read_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RESET_WAIT;
            r_stage_cnt <= '0;
            r_rst_cnt   <= '0;
            r_proto_err <= 1'b0;
`ifdef CNU_CTRL_EARLY_TERM_EN
            r_early     <= 1'b0;
`endif
        end else begin
            if (layer_finish && (r_state != ST_LAYER_WAIT)) begin
                r_proto_err <= 1'b1;
            end

            if (!fsm_en) begin
                r_state     <= ST_FRAME_IDLE;
                r_stage_cnt <= '0;
`ifdef CNU_CTRL_EARLY_TERM_EN
                r_early     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_RESET_WAIT: begin
                        if (r_rst_cnt == RST_LAST) begin
                            r_state <= ST_FRAME_IDLE;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    ST_FRAME_IDLE: begin
                        if (frame_valid) begin
                            r_state <= ST_VNU_PEND;
`ifdef CNU_CTRL_EARLY_TERM_EN
                            r_early <= 1'b0;
`endif
                        end
                    end
                    ST_VNU_PEND: begin
                        if (!vnu_update_pend) begin
                            r_state     <= ST_MEM_FETCH;
                            r_stage_cnt <= MEM_LOAD;
                        end
                    end
                    ST_MEM_FETCH: begin
                        if (w_stage_zero) begin
                            r_state     <= ST_CNU_PIPE;
                            r_stage_cnt <= CNU_LOAD;
                        end else begin
                            r_stage_cnt <= r_stage_cnt - 1'b1;
                        end
                    end
                    ST_CNU_PIPE: begin
                        if (w_stage_zero) begin
                            r_state <= ST_CNU_OUT;
                        end else begin
                            r_stage_cnt <= r_stage_cnt - 1'b1;
                        end
                    end
                    ST_CNU_OUT: begin
                        r_state     <= ST_BS_WB;
                        r_stage_cnt <= PERM_LOAD;
                    end
                    ST_BS_WB: begin
                        if (w_stage_zero) begin
                            if (PAGE_ALIGN_LEVEL > 0) begin
                                r_state     <= ST_PAGE_ALIGN;
                                r_stage_cnt <= PA_LOAD;
                            end else begin
                                r_state <= ST_MEM_WB;
                            end
                        end else begin
                            r_stage_cnt <= r_stage_cnt - 1'b1;
                        end
                    end
                    ST_PAGE_ALIGN: begin
                        if (w_stage_zero) begin
                            r_state <= ST_MEM_WB;
                        end else begin
                            r_stage_cnt <= r_stage_cnt - 1'b1;
                        end
                    end
                    ST_MEM_WB: begin
                        r_state <= ST_LAYER_WAIT;
                    end
                    ST_LAYER_WAIT: begin
                        if (layer_finish) begin
                            if (w_term) begin
                                r_state <= ST_DONE;
`ifdef CNU_CTRL_EARLY_TERM_EN
                                r_early <= w_early_hit;
`endif
                            end else if (!vnu_update_pend) begin
                                r_state     <= ST_MEM_FETCH;
                                r_stage_cnt <= MEM_LOAD;
                            end else begin
                                r_state <= ST_VNU_PEND;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_FRAME_IDLE;
                    end
                    default: begin
                        r_state <= ST_FRAME_IDLE;
                    end
                endcase
            end
        end
    end

    // Strobes decode straight from the registered state and stage counter.
    assign frame_ready   = (r_state == ST_FRAME_IDLE);
    assign v2c_mem_fetch = (r_state == ST_MEM_FETCH) && (r_stage_cnt == MEM_LOAD);
    assign cnu_rd        = (r_state == ST_CNU_PIPE) || (r_state == ST_CNU_OUT);
    assign c2v_bs_en     = (r_state == ST_BS_WB) && (r_stage_cnt == PERM_LOAD);
    assign c2v_pa_en     = (r_state == ST_PAGE_ALIGN);
    assign c2v_mem_we    = (r_state == ST_MEM_WB);
    assign frame_done    = (r_state == ST_DONE);
    assign last_layer    = w_last_layer;
    assign proto_err     = r_proto_err;
    assign state         = r_state;
`ifdef CNU_CTRL_EARLY_TERM_EN
    assign early_term    = (r_state == ST_DONE) && r_early;
`endif

endmodule

// File: tb/tb_layered_cnu_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layered_cnu_sched_ctrl
// Directed bench for layered_cnu_sched_ctrl. Each strobe event is recorded as
// {cycle offset since last v2c_mem_fetch, strobe vector, layer, iteration};
// the stimulus pushes hand-derived records into exp_q and a monitor pops and
// compares them whenever the DUT raises a strobe.
// Strobe vector bits: 0 fetch, 1 cnu_rd, 2 bs_en, 3 pa_en, 4 mem_we,
// 5 frame_done, 6 early_term.
// -----------------------------------------------------------------------------
module tb_layered_cnu_sched_ctrl;
    import layered_cnu_sched_ctrl_pkg::*;

    localparam int LN = DEF_LAYER_NUM;
`ifdef CNU_CTRL_EARLY_TERM_EN
    localparam int MI = DEF_MAX_ITER;
`else
    localparam int MI = 2;
`endif
    localparam int LW   = $clog2(LN);
    localparam int IW   = (MI > 1) ? $clog2(MI) : 1;
    localparam int RECW = 8 + 7 + LW + IW;

    // ---------------- clock / reset ----------------
    logic read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    logic            rst;
    logic            fsm_en;
    logic            frame_valid;
    logic            frame_ready;
    logic            vnu_update_pend;
    logic            layer_finish;
    logic            v2c_mem_fetch;
    logic            cnu_rd;
    logic            c2v_bs_en;
    logic            c2v_pa_en;
    logic            c2v_mem_we;
    logic [LW-1:0]   layer_idx;
    logic [IW-1:0]   iter_idx;
    logic            last_layer;
    logic            frame_done;
    logic            proto_err;
    logic [ST_W-1:0] state;
    logic            early_w;
`ifdef CNU_CTRL_EARLY_TERM_EN
    logic            syndrome_ok;
    logic            early_term;
    assign early_w = early_term;
`else
    assign early_w = 1'b0;
`endif

    layered_cnu_sched_ctrl #(
        .LAYER_NUM (LN),
        .MAX_ITER  (MI)
    ) dut (
        .read_clk        (read_clk),
        .rst             (rst),
        .fsm_en          (fsm_en),
        .frame_valid     (frame_valid),
        .frame_ready     (frame_ready),
        .vnu_update_pend (vnu_update_pend),
        .layer_finish    (layer_finish),
        .v2c_mem_fetch   (v2c_mem_fetch),
        .cnu_rd          (cnu_rd),
        .c2v_bs_en       (c2v_bs_en),
        .c2v_pa_en       (c2v_pa_en),
        .c2v_mem_we      (c2v_mem_we),
        .layer_idx       (layer_idx),
        .iter_idx        (iter_idx),
        .last_layer      (last_layer),
        .frame_done      (frame_done),
        .proto_err       (proto_err),
`ifdef CNU_CTRL_EARLY_TERM_EN
        .syndrome_ok     (syndrome_ok),
        .early_term      (early_term),
`endif
        .state           (state)
    );

    // ---------------- scoreboard ----------------
    logic [RECW-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_we    = 0;
    int n_done  = 0;
    int mon_off = 0;

    function automatic logic [RECW-1:0] mk(input int off, input logic [6:0] s,
                                           input int l, input int it);
        return {8'(off), s, LW'(l), IW'(it)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected strobe timeline of one layer with default latencies.
    task automatic push_layer(input int l, input int it);
        exp_q.push_back(mk(0, 7'h01, l, it));
        for (int o = 2; o <= 5; o++) exp_q.push_back(mk(o, 7'h02, l, it));
        exp_q.push_back(mk(6, 7'h04, l, it));
        exp_q.push_back(mk(8, 7'h08, l, it));
        exp_q.push_back(mk(9, 7'h10, l, it));
    endtask

    // layer_finish is pulsed at offset 10, so DONE is seen at offset 11.
    task automatic push_done(input int l, input int it, input bit early);
        exp_q.push_back(mk(11, early ? 7'h60 : 7'h20, l, it));
    endtask

    // monitor
    initial begin
        logic [6:0]      strb;
        logic [RECW-1:0] act;
        logic [RECW-1:0] exp;
        forever begin
            @(negedge read_clk);
            if (!rst) begin
                strb = {early_w, frame_done, c2v_mem_we, c2v_pa_en, c2v_bs_en, cnu_rd, v2c_mem_fetch};
                if (v2c_mem_fetch) mon_off = 0;
                else if (mon_off < 255) mon_off++;
                if (c2v_mem_we) n_we++;
                if (frame_done) n_done++;
                if (strb != 7'h00) begin
                    act = {8'(mon_off), strb, layer_idx, iter_idx};
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected: got %0h expected nothing", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act === exp) n_pass++;
                        else $display("FAIL sb_event: got %0h expected %0h", act, exp);
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_fetch();
        int n = 0;
        while (!v2c_mem_fetch && n < 60) begin
            @(negedge read_clk);
            n++;
        end
        check("fetch_wait", v2c_mem_fetch, 1);
    endtask

    // Starts at (or before) the layer's fetch cycle, ends one cycle after the
    // layer_finish pulse.
    task automatic run_layer(input int proto, input int pend_after, input int syn);
        wait_fetch();
        if (proto != 0) begin
            repeat (6) @(negedge read_clk);
            check("proto_err_before", proto_err, 0);
            layer_finish = 1'b1;
            @(negedge read_clk);
            layer_finish = 1'b0;
            check("proto_err_set", proto_err, 1);
            repeat (3) @(negedge read_clk);
        end else begin
            repeat (10) @(negedge read_clk);
        end
        check("layer_wait", state, ST_LAYER_WAIT);
        layer_finish = 1'b1;
        if (pend_after > 0) vnu_update_pend = 1'b1;
`ifdef CNU_CTRL_EARLY_TERM_EN
        syndrome_ok = (syn != 0);
`endif
        @(negedge read_clk);
        layer_finish = 1'b0;
`ifdef CNU_CTRL_EARLY_TERM_EN
        syndrome_ok = 1'b0;
`endif
        if (syn != 0) check("syn_done", frame_done, 1);
        if (pend_after > 0) begin
            for (int k = 0; k < pend_after; k++) begin
                check("pend_state", state, ST_VNU_PEND);
                check("pend_no_fetch", v2c_mem_fetch, 0);
                if (k == pend_after - 1) vnu_update_pend = 1'b0;
                @(negedge read_clk);
            end
            check("pend_release", state, ST_MEM_FETCH);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        fsm_en          = 1'b1;
        frame_valid     = 1'b1;
        vnu_update_pend = 1'b0;
        layer_finish    = 1'b0;
`ifdef CNU_CTRL_EARLY_TERM_EN
        syndrome_ok     = 1'b0;
`endif
        repeat (3) @(negedge read_clk);

        check("rst_state", state, ST_RESET_WAIT);
        check("rst_ready", frame_ready, 0);
        check("rst_strobes", {early_w, frame_done, c2v_mem_we, c2v_pa_en, c2v_bs_en, cnu_rd, v2c_mem_fetch}, 0);
        check("rst_idx", {layer_idx, iter_idx}, 0);
        check("rst_proto", proto_err, 0);

        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge read_clk);
            if (i == 99) check("ready_cycle99", frame_ready, 0);
        end
        check("ready_cycle100", frame_ready, 1);
        check("idle_state", state, ST_FRAME_IDLE);

        // Frame 1: full MI iterations, protocol error, pend at a boundary.
        for (int it = 0; it < MI; it++)
            for (int l = 0; l < LN; l++) push_layer(l, it);
        push_done(LN - 1, MI - 1, 1'b0);

        @(negedge read_clk);
        check("accept_state", state, ST_VNU_PEND);
        check("busy_not_ready", frame_ready, 0);
        frame_valid = 1'b0;

        for (int it = 0; it < MI; it++)
            for (int l = 0; l < LN; l++)
                run_layer((it == 0 && l == 0) ? 1 : 0, (it == 0 && l == 1) ? 3 : 0, 0);
        @(negedge read_clk);
        check("frame1_ready", frame_ready, 1);
        check("frame1_we_count", n_we, LN * MI);
        check("frame1_done_count", n_done, 1);

        // Frame 2: abort with fsm_en=0 in the middle of CNU_PIPE of layer 1.
        frame_valid = 1'b1;
        @(negedge read_clk);
        check("f2_accept", state, ST_VNU_PEND);
        frame_valid = 1'b0;
        push_layer(0, 0);
        exp_q.push_back(mk(0, 7'h01, 1, 0));
        exp_q.push_back(mk(2, 7'h02, 1, 0));
        exp_q.push_back(mk(3, 7'h02, 1, 0));
        run_layer(0, 0, 0);
        wait_fetch();
        repeat (3) @(negedge read_clk);
        check("abort_pre_state", state, ST_CNU_PIPE);
        check("abort_pre_layer", layer_idx, 1);
        fsm_en = 1'b0;
        @(negedge read_clk);
        fsm_en = 1'b1;
        check("abort_state", state, ST_FRAME_IDLE);
        check("abort_idx", {layer_idx, iter_idx}, 0);
        check("abort_no_done", n_done, 1);

`ifdef CNU_CTRL_EARLY_TERM_EN
        // Frame 3: syndrome satisfied at the end of layer 2, iteration 0.
        frame_valid = 1'b1;
        @(negedge read_clk);
        frame_valid = 1'b0;
        for (int l = 0; l < LN; l++) push_layer(l, 0);
        push_done(LN - 1, 0, 1'b1);
        run_layer(0, 0, 0);
        run_layer(0, 0, 0);
        run_layer(0, 0, 1);
        @(negedge read_clk);
        check("et_ready", frame_ready, 1);
        check("et_iter_hold", iter_idx, 0);
        check("et_done_count", n_done, 2);
`endif

        repeat (2) @(negedge read_clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("proto_sticky", proto_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
